dbg_probe_reader: RTL and testbench

//  Host-side reader for the CPU core's debug probe ports. Drives regfile_req_dbg / datamem_addr_dbg,

---
 rtl/dbg_probe_reader.sv | 173 +++++++++++++++++
 tb/tb_dbg_probe_reader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dbg_probe_reader.sv
// Debug probe sweeper: walks a range of the core's register file or data memory
// through its debug probe ports and streams each word out over valid/ready.
module dbg_probe_reader #(
    parameter int unsigned DM_ADDR_BIT = 10,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned CNT_BIT     = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   sel_dm,
    input  logic [DM_ADDR_BIT-1:0] base_addr,
    input  logic [CNT_BIT-1:0]     count,
    output logic [4:0]             regfile_req_dbg,
    output logic [DM_ADDR_BIT-1:0] datamem_addr_dbg,
    input  logic [31:0]            regfile_data_dbg,
    input  logic [31:0]            datamem_data_dbg,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [31:0]            m_data,
    output logic [DM_ADDR_BIT-1:0] m_index,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_FIN
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

    state_t                 r_state;
    logic                   r_sel;
    logic [DM_ADDR_BIT-1:0] r_addr;
    logic [CNT_BIT-1:0]     r_remaining;
    logic [3:0]             r_wait;
    logic [4:0]             r_rf_req;
    logic [DM_ADDR_BIT-1:0] r_dm_addr;
    logic                   r_m_valid;
    logic [31:0]            r_m_data;
    logic [DM_ADDR_BIT-1:0] r_m_index;
    logic                   r_m_last;
    logic                   r_busy;
    logic                   r_done;

    logic [DM_ADDR_BIT-1:0] w_next_addr;
    logic [DM_ADDR_BIT-1:0] w_base;
    logic [31:0]            w_rd_data;
    logic                   w_last_word;

    // RF indices live in the low 5 bits and wrap at 32; DM wraps at the full width.
    always_comb begin
        w_next_addr = '0;
        w_base      = '0;
        if (r_sel) begin
            w_next_addr = r_addr + 1'b1;
        end else begin
            w_next_addr[4:0] = r_addr[4:0] + 5'd1;
        end
        if (sel_dm) begin
            w_base = base_addr;
        end else begin
            w_base[4:0] = base_addr[4:0];
        end
    end

    assign w_rd_data   = r_sel ? datamem_data_dbg : regfile_data_dbg;
    assign w_last_word = (r_remaining == CNT_BIT'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_wait      <= '0;
            r_rf_req    <= '0;
            r_dm_addr   <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_index   <= '0;
            r_m_last    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (en) begin
            if (abort && (r_state != S_IDLE)) begin
                r_state   <= S_IDLE;
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_busy <= 1'b1;
                            if (count != '0) begin
                                r_sel       <= sel_dm;
                                r_addr      <= w_base;
                                r_remaining <= count;
                                r_state     <= S_ISSUE;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= S_FIN;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (r_sel) begin
                            r_dm_addr <= r_addr;
                            r_rf_req  <= '0;
                        end else begin
                            r_rf_req  <= r_addr[4:0];
                            r_dm_addr <= '0;
                        end
                        r_wait  <= LAT_INIT;
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (r_wait == 4'd0) begin
                            r_m_data  <= w_rd_data;
                            r_m_index <= r_addr;
                            r_m_valid <= 1'b1;
                            r_m_last  <= w_last_word;
                            r_state   <= S_EMIT;
                        end else begin
                            r_wait <= r_wait - 4'd1;
                        end
                    end
                    S_EMIT: begin
                        if (m_ready) begin
                            r_m_valid   <= 1'b0;
                            r_m_last    <= 1'b0;
                            r_remaining <= r_remaining - 1'b1;
                            r_addr      <= w_next_addr;
                            if (w_last_word) begin
                                r_done  <= 1'b1;
                                r_state <= S_FIN;
                            end else begin
                                r_state <= S_ISSUE;
                            end
                        end
                    end
                    S_FIN: begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign regfile_req_dbg  = r_rf_req;
    assign datamem_addr_dbg = r_dm_addr;
    assign m_valid          = r_m_valid;
    assign m_data           = r_m_data;
    assign m_index          = r_m_index;
    assign m_last           = r_m_last;
    assign busy             = r_busy;
    assign done             = r_done;

endmodule

// File: tb/tb_dbg_probe_reader.sv
// Randomized bench for dbg_probe_reader: a behavioural core probe model with
// RD_LAT latency, and expected words derived from base/count/wrap arithmetic.
module tb_dbg_probe_reader;

    localparam int DAB    = 10;
    localparam int CNTB   = 11;
    localparam int RD_LAT = 3;
    localparam int DMSZ   = 1 << DAB;

    logic            clk = 1'b0;
    logic            rst, en, start, abort, sel_dm, m_ready;
    logic [DAB-1:0]  base_addr;
    logic [CNTB-1:0] count;
    logic [4:0]      regfile_req_dbg;
    logic [DAB-1:0]  datamem_addr_dbg;
    logic [31:0]     regfile_data_dbg, datamem_data_dbg;
    logic            m_valid, m_last, busy, done;
    logic [31:0]     m_data;
    logic [DAB-1:0]  m_index;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dbg_probe_reader #(.DM_ADDR_BIT(DAB), .RD_LAT(RD_LAT), .CNT_BIT(CNTB)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort), .sel_dm(sel_dm),
        .base_addr(base_addr), .count(count),
        .regfile_req_dbg(regfile_req_dbg), .datamem_addr_dbg(datamem_addr_dbg),
        .regfile_data_dbg(regfile_data_dbg), .datamem_data_dbg(datamem_data_dbg),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
        .m_last(m_last), .busy(busy), .done(done)
    );

    // Core probe model: data follows the address after RD_LAT cycles (bench uses RD_LAT >= 2).
    logic [31:0]    rf [32];
    logic [31:0]    dm [DMSZ];
    logic [4:0]     rf_pipe [15];
    logic [DAB-1:0] dm_pipe [15];

    always @(posedge clk) begin
        rf_pipe[0] <= regfile_req_dbg;
        dm_pipe[0] <= datamem_addr_dbg;
        for (int i = 1; i < 15; i++) begin
            rf_pipe[i] <= rf_pipe[i-1];
            dm_pipe[i] <= dm_pipe[i-1];
        end
    end

    assign regfile_data_dbg = rf[rf_pipe[RD_LAT-2]];
    assign datamem_data_dbg = dm[dm_pipe[RD_LAT-2]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic int exp_idx(input bit sel, input int base, input int w);
        return sel ? (base + w) % DMSZ : ((base % 32) + w) % 32;
    endfunction

    task automatic run_sweep(input bit sel, input int base, input int cnt,
                             input int stall_w, input int stall_n, input int freeze_w);
        int words, k, idx, last_hs;
        logic [31:0] d;
        logic [DAB-1:0] ix;
        start = 1'b1; sel_dm = sel; base_addr = DAB'(base); count = CNTB'(cnt); m_ready = 1'b1;
        tick;
        start = 1'b0;
        check("busy_start", busy, 1);
        words = 0; k = 0; last_hs = -1;
        while (words < cnt && k < 300) begin
            // Mid-sweep start/config changes must be ignored.
            start = 1'($urandom); sel_dm = 1'($urandom);
            base_addr = DAB'($urandom); count = CNTB'($urandom);
            if (m_valid) begin
                idx = exp_idx(sel, base, words);
                if (words == 0) check("first_lat", 64'(k), 64'(RD_LAT + 1));
                else check("gap", 64'(k - last_hs), 64'(RD_LAT + 2));
                d = m_data; ix = m_index;
                if (words == stall_w) begin
                    m_ready = 1'b0;
                    repeat (stall_n) begin
                        tick; k++;
                        check("stall_valid", m_valid, 1);
                        check("stall_data", m_data, d);
                        check("stall_index", m_index, ix);
                    end
                    m_ready = 1'b1;
                end
                if (words == freeze_w) begin
                    en = 1'b0;
                    repeat (3) begin
                        tick; k++;
                        check("freeze_valid", m_valid, 1);
                        check("freeze_data", m_data, d);
                    end
                    en = 1'b1;
                end
                check("data", m_data, sel ? dm[idx] : rf[idx]);
                check("index", m_index, 64'(idx));
                check("last", m_last, 64'(words == cnt - 1));
                check("done_mid", done, 0);
                last_hs = k;
                words++;
            end
            tick; k++;
        end
        check("words", 64'(words), 64'(cnt));
        start = 1'b0;
        check("done_pulse", done, 1);
        check("valid_fin", m_valid, 0);
        tick;
        check("done_clear", done, 0);
        check("busy_clear", busy, 0);
    endtask

    task automatic abort_test(input int base);
        int words, k;
        start = 1'b1; sel_dm = 1'b1; base_addr = DAB'(base); count = CNTB'(8); m_ready = 1'b1;
        tick;
        start = 1'b0;
        words = 0; k = 0;
        while (k < 200 && !(words == 2 && m_valid)) begin
            if (m_valid) begin
                check("abort_pre_index", m_index, 64'(exp_idx(1'b1, base, words)));
                words++;
            end
            tick; k++;
        end
        check("abort_reach", 64'(words), 2);
        abort = 1'b1; m_ready = 1'b0;
        tick;
        abort = 1'b0; m_ready = 1'b1;
        check("abort_valid", m_valid, 0);
        check("abort_last", m_last, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_probe", datamem_addr_dbg, 64'(exp_idx(1'b1, base, 2)));
        tick;
        check("abort_done2", done, 0);
    endtask

    task automatic rst_test;
        int k;
        start = 1'b1; sel_dm = 1'b0; base_addr = DAB'(5); count = CNTB'(6); m_ready = 1'b0;
        tick;
        start = 1'b0;
        k = 0;
        while (!m_valid && k < 100) begin tick; k++; end
        check("rst_reach_emit", m_valid, 1);
        rst = 1'b1;
        tick;
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_index", m_index, 0);
        check("rst_busy", busy, 0);
        check("rst_rfreq", regfile_req_dbg, 0);
        rst = 1'b0; m_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; abort = 1'b0; sel_dm = 1'b0;
        base_addr = '0; count = '0; m_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        for (int i = 0; i < DMSZ; i++) dm[i] = $urandom;
        rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33; rf[4] = 32'h44;
        repeat (3) tick;
        check("rst_m_valid", m_valid, 0);
        check("rst_busy0", busy, 0);
        check("rst_done0", done, 0);
        check("rst_m_data0", m_data, 0);
        check("rst_m_index0", m_index, 0);
        check("rst_dm_addr0", datamem_addr_dbg, 0);
        rst = 1'b0;
        tick;

        run_sweep(1'b0, 1, 4, -1, 0, -1);
        run_sweep(1'b1, DMSZ - 2, 4, -1, 0, -1);
        run_sweep(1'b1, int'($urandom_range(0, DMSZ - 1)), 5, 1, 5, -1);
        run_sweep(1'b0, 3, 0, -1, 0, -1);
        abort_test(int'($urandom_range(0, DMSZ - 1)));
        run_sweep(1'b0, 30, 5, -1, 0, -1);
        rst_test();
        run_sweep(1'b1, int'($urandom_range(0, DMSZ - 1)), 4, -1, 0, 2);
        repeat (6) begin
            run_sweep(1'($urandom), int'($urandom_range(0, DMSZ - 1)), int'($urandom_range(1, 6)),
                      int'($urandom_range(0, 5)), int'($urandom_range(1, 4)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
